tri_intlv_buf: RTL

- Parametrised triangular bit interleaver/de-interleaver buffer; the successor to the fixed 128-side triangleSR.
- Accepts a frame of SIDE*(SIDE+1)/2 bits on a WR_W-wide valid/ready input and stores it in a triangle: row r holds r+1 bits at columns 0..r.
- Drains the frame on an RD_W-wide valid/ready output in the transposed order.
- Mode selects interleave or de-interleave. Sits between the bit scrambler and the symbol mapper in the TX path, and in mirror position in RX.

---
 rtl/tri_intlv_buf_if.sv | 25 ++
 rtl/tri_intlv_buf.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/tri_intlv_buf_if.sv
// Valid/ready bus pair for the triangular interleaver: input beat stream and output beat stream.
// The slave modport is the buffer's view; master is the upstream/downstream driver's view.
interface tri_intlv_buf_if #(
  parameter int WR_W = 32,
  parameter int RD_W = 38
);
  logic                        s_valid;
  logic                        s_ready;
  logic [WR_W-1:0]             s_data;
  logic                        m_valid;
  logic                        m_ready;
  logic [RD_W-1:0]             m_data;
  logic                        m_last;
  logic [$clog2(RD_W+1)-1:0]   m_nbits;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last, m_nbits
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last, m_nbits
  );
endinterface

// File: rtl/tri_intlv_buf.sv
// Triangular bit interleaver/de-interleaver: fills a SIDE-row triangle in one order and
// drains it in the transposed order. Storage is kept linear in row-major order.
module tri_intlv_buf #(
  parameter int SIDE  = 128,
  parameter int WR_W  = 32,
  parameter int RD_W  = 38,
  parameter int TOTAL = SIDE * (SIDE + 1) / 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_mode,
  input  logic              abort,
  tri_intlv_buf_if.slave    bus,
  output logic              busy,
  output logic              frame_done
);

  localparam int AW  = $clog2(TOTAL);
  localparam int CW  = $clog2(TOTAL + 1);
  localparam int RW  = $clog2(SIDE + 1);
  localparam int NBW = $clog2(RD_W + 1);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   wr_cnt, rd_cnt;
  logic [RW-1:0]   wr_r, wr_c, rd_r, rd_c;
  logic [RW-1:0]   wr_r_nxt, wr_c_nxt, rd_r_nxt, rd_c_nxt;
  logic            mode_q, ready_en, done_q;
  logic [TOTAL-1:0] mem;
  logic [AW-1:0]   wr_pos [WR_W];
  logic [RD_W-1:0] rd_bits;
  logic            wr_mode, wr_fire, rd_fire, last_beat;
  int              wr_n, rd_n;

  function automatic int tri_addr(input int r, input int c);
    return r * (r + 1) / 2 + c;
  endfunction

  // Mode is taken live on the first beat of a frame, then held for the rest of it.
  assign wr_mode   = (wr_cnt == '0) ? cfg_mode : mode_q;
  assign wr_n      = ((TOTAL - int'(wr_cnt)) < WR_W) ? (TOTAL - int'(wr_cnt)) : WR_W;
  assign rd_n      = ((TOTAL - int'(rd_cnt)) < RD_W) ? (TOTAL - int'(rd_cnt)) : RD_W;
  assign wr_fire   = bus.s_valid && bus.s_ready && !abort && !rst;
  assign rd_fire   = bus.m_valid && bus.m_ready && !abort && !rst;
  assign last_beat = (int'(rd_cnt) + RD_W) >= TOTAL;

  // Walk the write order from the current (row, col): row-major for mode 0, column-major for mode 1.
  always_comb begin : wr_walk
    int r, c;
    r = int'(wr_r);
    c = int'(wr_c);
    for (int i = 0; i < WR_W; i++) begin
      wr_pos[i] = '0;
      if (i < wr_n) begin
        wr_pos[i] = AW'(tri_addr(r, c));
        if (!wr_mode) begin
          if (c == r) begin
            r = r + 1;
            c = 0;
          end else begin
            c = c + 1;
          end
        end else begin
          if (r == SIDE - 1) begin
            c = c + 1;
            r = c;
          end else begin
            r = r + 1;
          end
        end
      end
    end
    wr_r_nxt = RW'(r);
    wr_c_nxt = RW'(c);
  end

  always_comb begin : rd_walk
    int r, c;
    r = int'(rd_r);
    c = int'(rd_c);
    rd_bits = '0;
    for (int j = 0; j < RD_W; j++) begin
      if (j < rd_n) begin
        rd_bits[j] = mem[AW'(tri_addr(r, c))];
        if (mode_q) begin
          if (c == r) begin
            r = r + 1;
            c = 0;
          end else begin
            c = c + 1;
          end
        end else begin
          if (r == SIDE - 1) begin
            c = c + 1;
            r = c;
          end else begin
            r = r + 1;
          end
        end
      end
    end
    rd_r_nxt = RW'(r);
    rd_c_nxt = RW'(c);
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (wr_fire && (int'(wr_cnt) + wr_n == TOTAL)) state_nxt = DRAIN;
      DRAIN:   if (rd_fire && last_beat) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_comb begin
    bus.s_ready = (state == FILL) && ready_en;
    bus.m_valid = (state == DRAIN);
    bus.m_data  = (state == DRAIN) ? rd_bits : '0;
    bus.m_nbits = (state == DRAIN) ? NBW'(rd_n) : '0;
    bus.m_last  = (state == DRAIN) && last_beat;
    busy        = (state == DRAIN) || (wr_cnt != '0);
    frame_done  = done_q;
  end

  // s_ready is held off for the whole reset and comes up one cycle after it releases.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
      wr_r   <= '0;
      wr_c   <= '0;
      rd_r   <= '0;
      rd_c   <= '0;
      done_q <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (wr_fire) begin
        wr_cnt <= wr_cnt + CW'(wr_n);
        wr_r   <= wr_r_nxt;
        wr_c   <= wr_c_nxt;
        if (wr_cnt == '0) mode_q <= cfg_mode;
      end
      if (rd_fire) begin
        if (last_beat) begin
          wr_cnt <= '0;
          rd_cnt <= '0;
          wr_r   <= '0;
          wr_c   <= '0;
          rd_r   <= '0;
          rd_c   <= '0;
          done_q <= 1'b1;
        end else begin
          rd_cnt <= rd_cnt + CW'(rd_n);
          rd_r   <= rd_r_nxt;
          rd_c   <= rd_c_nxt;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < WR_W; i++) begin
      if (wr_fire && (i < wr_n)) mem[wr_pos[i]] <= bus.s_data[i];
    end
  end

endmodule
